alu_req_sequencer: RTL

- Two-requester front end for the shared 8-bit ALU (ALU_8b: 4-bit select, 8-bit A/B, 8-bit result, carry-out).
- Arbitrates requests round-robin, latches one operation, holds ALU inputs stable for its modelled latency, captures result/carry, returns the response with valid/ready.
- Handles divide-by-zero locally; one operation in flight at a time.

---
 rtl/alu_req_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_req_sequencer.sv
// Two-requester round-robin front end for the shared 8-bit ALU: accepts one op at a time,
// holds the ALU inputs for the op's latency, then returns the captured result via valid/ready.
module alu_req_sequencer #(
    parameter int WIDTH      = 8,
    parameter int MULDIV_LAT = 3,
    parameter int BASE_LAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_carry,
    output logic             resp_dz,
    output logic             busy
);

    localparam int LAT_MAX = (MULDIV_LAT > BASE_LAT) ? MULDIV_LAT : BASE_LAT;
    localparam int CNT_W   = (LAT_MAX < 1) ? 1 : $clog2(LAT_MAX + 1);
    localparam logic [CNT_W-1:0] MULDIV_CNT = CNT_W'(MULDIV_LAT);
    localparam logic [CNT_W-1:0] BASE_CNT   = CNT_W'(BASE_LAT);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state, state_next;
    logic               last_grant;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               id_q;
    logic [CNT_W-1:0]   cnt;

    logic               grant_any;
    logic               grant_id;
    logic [3:0]         sel_op;
    logic [WIDTH-1:0]   sel_a, sel_b;
    logic               div_zero;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == 4'b0010) || (op == 4'b0011);
    endfunction

    // On a tie the requester that was not served last wins; a lone requester always wins.
    assign grant_any = !rst && (state == IDLE) && (req0_valid || req1_valid);
    assign grant_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign sel_op    = grant_id ? req1_op : req0_op;
    assign sel_a     = grant_id ? req1_a  : req0_a;
    assign sel_b     = grant_id ? req1_b  : req0_b;
    assign div_zero  = (op_q == 4'b0011) && (b_q == '0);

    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        alu_sel    = '0;
        alu_a      = '0;
        alu_b      = '0;
        resp_valid = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                req0_ready = grant_any && !grant_id;
                req1_ready = grant_any && grant_id;
                if (grant_any) state_next = EXEC;
            end
            EXEC: begin
                alu_sel = op_q;
                alu_a   = a_q;
                alu_b   = b_q;
                if (cnt == '0) state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            cnt         <= '0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_carry  <= 1'b0;
            resp_dz     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_q <= sel_op;
                        a_q  <= sel_a;
                        b_q  <= sel_b;
                        id_q <= grant_id;
                        cnt  <= is_muldiv(sel_op) ? MULDIV_CNT : BASE_CNT;
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // Divide by zero is answered locally; whatever the ALU drives is ignored.
                        resp_id     <= id_q;
                        resp_result <= div_zero ? '1 : alu_out;
                        resp_carry  <= div_zero ? 1'b0 : alu_carry;
                        resp_dz     <= div_zero;
                    end
                end
                RESP: begin
                    if (resp_ready) last_grant <= resp_id;
                end
                default: ;
            endcase
        end
    end

endmodule
